// File: rtl/me_stage.sv
// Memory-access pipeline stage: latches the execute payload, picks the ALU result or SRAM
// read data, keeps a stalled load's read data, and feeds forwarding back to decode.
module me_stage #(
    parameter int EX_BUS_W = 71,
    parameter int WB_BUS_W = 70
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                EX_to_ME_Valid,
    input  logic [EX_BUS_W-1:0] EX_to_ME_Bus,
    output logic                ME_Allow_in,
    input  logic [31:0]         data_sram_rdata,
    output logic                ME_to_WB_Valid,
    input  logic                WB_Allow_in,
    output logic [WB_BUS_W-1:0] ME_to_WB_Bus,
    output logic [4:0]          ME_dest,
    output logic [31:0]         ME_Forward_Res
);

    logic                me_valid_reg;
    logic [EX_BUS_W-1:0] payload_reg;
    logic                first_cyc_reg;
    logic                rbuf_valid_reg;
    logic [31:0]         rbuf_reg;

    logic [31:0] pc;
    logic [31:0] alu_result;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic        me_ready_go;
    logic        capture;

    assign pc           = payload_reg[70:39];
    assign alu_result   = payload_reg[38:7];
    assign res_from_mem = payload_reg[6];
    assign gr_we        = payload_reg[5];
    assign dest         = payload_reg[4:0];

    assign me_ready_go    = 1'b1;
    assign ME_Allow_in    = !me_valid_reg || (me_ready_go && WB_Allow_in);
    assign ME_to_WB_Valid = me_valid_reg && me_ready_go;

    // SRAM data lasts only one cycle, so a load that cannot leave in its first cycle keeps it here.
    assign capture = me_valid_reg && first_cyc_reg && res_from_mem && !WB_Allow_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            me_valid_reg   <= 1'b0;
            payload_reg    <= '0;
            first_cyc_reg  <= 1'b0;
            rbuf_valid_reg <= 1'b0;
            rbuf_reg       <= '0;
        end else begin
            if (ME_Allow_in) begin
                me_valid_reg <= EX_to_ME_Valid;
                if (EX_to_ME_Valid) begin
                    payload_reg    <= EX_to_ME_Bus;
                    first_cyc_reg  <= 1'b1;
                    rbuf_valid_reg <= 1'b0;
                end
            end else begin
                first_cyc_reg <= 1'b0;
            end
            if (capture) begin
                rbuf_reg       <= data_sram_rdata;
                rbuf_valid_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        final_result = alu_result;
        if (res_from_mem) begin
            final_result = rbuf_valid_reg ? rbuf_reg : data_sram_rdata;
        end
    end

    assign ME_to_WB_Bus   = {pc, final_result, gr_we, dest};
    assign ME_Forward_Res = final_result;

    for (genvar gi = 0; gi < 5; gi++) begin : g_dest
        assign ME_dest[gi] = dest[gi] & me_valid_reg;
    end

    // A held load past its first cycle must be served from the capture register.
    a_load_has_data: assert property (@(posedge clk) disable iff (reset)
        !(me_valid_reg && res_from_mem && !first_cyc_reg && !rbuf_valid_reg));

endmodule

// File: tb/tb_me_stage.sv
// Scoreboard bench for me_stage: expected WB payloads are queued on acceptance and
// compared every cycle the stage holds them.
module tb_me_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [70:0] ex_bus;
    logic        allow_in;
    logic [31:0] rdata;
    logic        wb_valid;
    logic        wb_allow;
    logic [69:0] wb_bus;
    logic [4:0]  me_dest;
    logic [31:0] fwd_res;

    me_stage dut (
        .clk             (clk),
        .reset           (reset),
        .EX_to_ME_Valid  (ex_valid),
        .EX_to_ME_Bus    (ex_bus),
        .ME_Allow_in     (allow_in),
        .data_sram_rdata (rdata),
        .ME_to_WB_Valid  (wb_valid),
        .WB_Allow_in     (wb_allow),
        .ME_to_WB_Bus    (wb_bus),
        .ME_dest         (me_dest),
        .ME_Forward_Res  (fwd_res)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] res;
        logic        we;
        logic [4:0]  dest;
        logic        load;
    } exp_t;

    exp_t q[$];
    logic m_valid;
    logic m_first;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                         input logic rfm, input logic we, input logic [4:0] dst,
                         input logic wb, input logic [31:0] rd);
        ex_valid = v;
        ex_bus   = {pc, alu, rfm, we, dst};
        wb_allow = wb;
        rdata    = rd;
    endtask

    // Compare outputs at the falling edge, with inputs for this cycle already stable.
    task automatic settle();
        exp_t e;
        @(negedge clk);
        check("allow_in", {69'd0, allow_in}, {69'd0, !m_valid || wb_allow});
        check("wb_valid", {69'd0, wb_valid}, {69'd0, m_valid});
        if (m_valid) begin
            check("queue_nonempty", {69'd0, q.size() != 0}, 70'd1);
            if (q.size() != 0) begin
                if (m_first && q[0].load) q[0].res = rdata;
                e = q[0];
                check("me_dest", {65'd0, me_dest}, {65'd0, e.dest});
                check("fwd_res", {38'd0, fwd_res}, {38'd0, e.res});
                check("bus", wb_bus, {e.pc, e.res, e.we, e.dest});
                if (wb_allow) begin
                    $display("xfer pc=%h res=%h we=%0d dest=%0d", e.pc, e.res, e.we, e.dest);
                    void'(q.pop_front());
                end
            end
        end else begin
            check("me_dest_empty", {65'd0, me_dest}, 70'd0);
        end
    endtask

    task automatic advance();
        exp_t e;
        if (!m_valid || wb_allow) begin
            m_valid = ex_valid;
            m_first = ex_valid;
            if (ex_valid) begin
                e.pc   = ex_bus[70:39];
                e.res  = ex_bus[38:7];
                e.load = ex_bus[6];
                e.we   = ex_bus[5];
                e.dest = ex_bus[4:0];
                q.push_back(e);
            end
        end else begin
            m_first = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                       input logic rfm, input logic [4:0] dst, input logic wb,
                       input logic [31:0] rd);
        drive(v, pc, alu, rfm, 1'b1, dst, wb, rd);
        settle();
        advance();
    endtask

    task automatic idle(input logic wb, input logic [31:0] rd);
        cyc(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, wb, rd);
    endtask

    initial begin
        m_valid = 1'b0;
        m_first = 1'b0;
        reset   = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 32'd0);
        #1;
        check("rst_valid", {69'd0, wb_valid}, 70'd0);
        check("rst_dest", {65'd0, me_dest}, 70'd0);
        check("rst_allow", {69'd0, allow_in}, 70'd1);
        #11 reset = 1'b0;
        @(posedge clk);
        #1;

        // ALU pass-through with an explicit literal check of the WB payload
        cyc(1'b1, 32'h1C000000, 32'h12345678, 1'b0, 5'd5, 1'b1, 32'h0);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0);
        settle();
        check("t1_bus_lit", wb_bus, {32'h1C000000, 32'h12345678, 1'b1, 5'd5});
        advance();

        // Load without stall
        cyc(1'b1, 32'h1C000004, 32'h0, 1'b1, 5'd6, 1'b1, 32'h0);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 32'hDEADBEEF);
        settle();
        check("t2_fwd_lit", {38'd0, fwd_res}, {38'd0, 32'hDEADBEEF});
        advance();

        // Load with a 3-cycle WB stall; SRAM data turns to garbage after the first cycle
        cyc(1'b1, 32'h1C000008, 32'h0, 1'b1, 5'd7, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, (i == 0) ? 32'hCAFEF00D : 32'hFFFFFFFF);
            settle();
            check("t3_stall_lit", {38'd0, fwd_res}, {38'd0, 32'hCAFEF00D});
            check("t3_allow_lo", {69'd0, allow_in}, 70'd0);
            advance();
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 32'hFFFFFFFF);
        settle();
        check("t3_release_lit", {38'd0, fwd_res}, {38'd0, 32'hCAFEF00D});
        advance();

        // Back-to-back load then ALU op
        cyc(1'b1, 32'h1C00000C, 32'h0, 1'b1, 5'd8, 1'b1, 32'h0);
        cyc(1'b1, 32'h1C000010, 32'h00000042, 1'b0, 5'd9, 1'b1, 32'hDEADBEEF);
        idle(1'b1, 32'h0);

        // Non-load held under stall while upstream offers another instruction
        cyc(1'b1, 32'h1C000014, 32'hA5A5A5A5, 1'b0, 5'd4, 1'b1, 32'h0);
        cyc(1'b1, 32'h1C000018, 32'h11111111, 1'b0, 5'd2, 1'b0, 32'h77777777);
        cyc(1'b1, 32'h1C000018, 32'h11111111, 1'b0, 5'd2, 1'b0, 32'h88888888);
        cyc(1'b1, 32'h1C000018, 32'h11111111, 1'b0, 5'd2, 1'b1, 32'h99999999);
        idle(1'b1, 32'h0);

        // Async reset in the middle of a load stall
        cyc(1'b1, 32'h1C00001C, 32'h0, 1'b1, 5'd10, 1'b1, 32'h0);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h13572468);
        settle();
        #1 reset = 1'b1;
        #1;
        check("t5_valid", {69'd0, wb_valid}, 70'd0);
        check("t5_dest", {65'd0, me_dest}, 70'd0);
        check("t5_allow", {69'd0, allow_in}, 70'd1);
        q.delete();
        m_valid = 1'b0;
        m_first = 1'b0;
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Drain followed by two bubbles
        cyc(1'b1, 32'h1C000020, 32'h0BADCAFE, 1'b0, 5'd3, 1'b1, 32'h0);
        idle(1'b1, 32'h0);
        idle(1'b1, 32'h0);
        idle(1'b1, 32'h0);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            cyc(1'($urandom_range(0, 1)), 32'h1C001000 + 32'(i * 4), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                ($urandom_range(0, 3) != 0), $urandom);
        end
        for (int i = 0; i < 3; i++) idle(1'b1, 32'h0);
        check("queue_drained", 70'(q.size()), 70'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
